// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch FSM with one-entry stall buffer and redirect discard handling
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_inst,
  output logic [21:0] id_imm_field,
  output logic [31:0] id_pc,
  output logic        id_valid
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DISCARD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] pend_q, pend_d;

  // pc_q is never advanced while a request is outstanding, so it is also the abandoned address in DISCARD
  assign imem_req     = (state_q == WAIT) || (state_q == DISCARD);
  assign imem_addr    = pc_q;
  assign id_inst      = id_inst_q;
  assign id_imm_field = id_inst_q[21:0];
  assign id_pc        = id_pc_q;
  assign id_valid     = id_valid_q;

  // next-state and datapath updates; redirect always wins over stall
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    id_valid_d  = id_valid_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    pend_d      = pend_q;
    case (state_q)
      IDLE: state_d = WAIT;
      WAIT: begin
        if (imem_ack && redirect_valid) begin
          pc_d       = redirect_pc;
          id_valid_d = 1'b0;
        end else if (imem_ack && !stall) begin
          id_inst_d  = imem_rdata;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          pc_d       = pc_q + PC_STEP;
        end else if (imem_ack) begin
          hold_inst_d = imem_rdata;
          hold_pc_d   = pc_q;
          pc_d        = pc_q + PC_STEP;
          state_d     = HOLD;
        end else if (redirect_valid) begin
          pend_d     = redirect_pc;
          id_valid_d = 1'b0;
          state_d    = DISCARD;
        end else if (!stall) begin
          id_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          hold_inst_d = '0;
          hold_pc_d   = '0;
          pc_d        = redirect_pc;
          id_valid_d  = 1'b0;
          state_d     = WAIT;
        end else if (!stall) begin
          id_inst_d  = hold_inst_q;
          id_pc_d    = hold_pc_q;
          id_valid_d = 1'b1;
          state_d    = WAIT;
        end
      end
      DISCARD: begin
        id_valid_d = 1'b0;
        pend_d     = redirect_valid ? redirect_pc : pend_q;
        pc_d       = imem_ack ? (redirect_valid ? redirect_pc : pend_q) : pc_q;
        state_d    = imem_ack ? WAIT : DISCARD;
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      id_inst_q   <= '0;
      id_pc_q     <= '0;
      id_valid_q  <= 1'b0;
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      id_valid_q  <= id_valid_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      pend_q      <= pend_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage against an instruction-stream model
module tb_fetch_stage;
  localparam logic [31:0] RPC = 32'hFFFF_FFFD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] id_inst;
  logic [21:0] id_imm_field;
  logic [31:0] id_pc;
  logic        id_valid;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .PC_STEP(32'd1)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_inst(id_inst),
    .id_imm_field(id_imm_field), .id_pc(id_pc), .id_valid(id_valid)
  );

  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} item_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  item_t       exp_q[$];
  logic [31:0] want_pc, last_addr, buf_pc, buf_inst;
  bit          discarding, in_req, buf_valid, exp_valid, first;

  // memory contents: a fixed scramble of the address
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    want_pc = RPC;
    discarding = 0;
    in_req = 0;
    buf_valid = 0;
    exp_valid = 0;
    first = 1;
    exp_q.delete();
  endtask

  // one cycle at the negedge: check outputs, drive inputs, advance the stream model
  task automatic step(input bit quiet);
    bit          req, acc;
    logic [31:0] addr;
    req  = imem_req;
    addr = imem_addr;
    chk("imem_req", 32'(req), 32'(!first && !buf_valid));
    if (req) chk("imem_addr", addr, in_req ? last_addr : want_pc);
    chk("id_valid", 32'(id_valid), 32'(exp_valid));
    stall          = quiet ? 1'b0 : ($urandom_range(0, 9) < 3);
    redirect_valid = !quiet && !first && ($urandom_range(0, 7) == 0);
    redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 255));
    imem_ack       = req && !quiet && ($urandom_range(0, 1) == 0);
    imem_rdata     = imem_ack ? mem(addr) : $urandom;
    acc = req && imem_ack;
    if (redirect_valid) begin
      buf_valid  = 0;
      exp_valid  = 0;
      want_pc    = redirect_pc;
      discarding = req && !imem_ack;
    end else if (acc && !discarding) begin
      want_pc = addr + 32'd1;
      if (stall) begin
        buf_valid = 1;
        buf_pc    = addr;
        buf_inst  = mem(addr);
      end else begin
        exp_q.push_back('{pc: addr, inst: mem(addr)});
        exp_valid = 1;
      end
    end else if (acc) begin
      discarding = 0;
      exp_valid  = 0;
    end else if (buf_valid && !stall) begin
      exp_q.push_back('{pc: buf_pc, inst: buf_inst});
      buf_valid = 0;
      exp_valid = 1;
    end else if (!stall) begin
      exp_valid = 0;
    end
    in_req    = req && !imem_ack;
    last_addr = addr;
    first     = 0;
  endtask

  logic  m_s, m_r, m_e;
  item_t m_it;

  // monitor: a valid id output after an unstalled, unredirected edge is a new delivery
  always begin
    @(posedge clk);
    m_s = stall;
    m_r = redirect_valid;
    m_e = rst_n;
    #1;
    if (m_e && rst_n) begin
      chk("id_imm_field", {10'd0, id_imm_field}, {10'd0, id_inst[21:0]});
      if (id_valid && !m_s && !m_r) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_delivery: got pc %h with nothing expected", id_pc);
        end else begin
          m_it = exp_q.pop_front();
          chk("id_pc", id_pc, m_it.pc);
          chk("id_inst", id_inst, m_it.inst);
        end
      end
    end
  end

  task automatic reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(id_valid), 32'd0);
    chk({tag, "_inst"}, id_inst, 32'd0);
    chk({tag, "_imm"}, {10'd0, id_imm_field}, 32'd0);
    chk({tag, "_pc"}, id_pc, 32'd0);
  endtask

  initial begin
    model_reset();
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    reset_outputs("rst0");
    imem_ack = 1'b0;
    rst_n    = 1'b1;
    repeat (2000) begin
      step(0);
      @(negedge clk);
    end
    #2;
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0BAD_0BAD;
    #1;
    reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    reset_outputs("rst_hold");
    imem_ack = 1'b0;
    rst_n    = 1'b1;
    repeat (2000) begin
      step(0);
      @(negedge clk);
    end
    repeat (6) begin
      step(1);
      @(negedge clk);
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 32'd1, PC increment per fetched instruction (word addressing).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 stall  input  1  decode cannot accept a new instruction this cycle.
REQ-006 redirect_valid  input  1  branch/jump taken; the fetch path changes to redirect_pc.
REQ-007 redirect_pc  input  32  redirect target address.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  request address.
REQ-010 imem_ack  input  1  memory data valid; may arrive in the same cycle as imem_req or any later cycle.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-012 id_inst  output  32  registered instruction presented to decode and the immediate generator.
REQ-013 id_imm_field  output  22  registered copy of id_inst[21:0].
REQ-014 id_pc  output  32  address of id_inst.
REQ-015 id_valid  output  1  id_inst holds a real instruction; 0 means bubble.

Function
REQ-016 The FSM SHALL have four states: IDLE, WAIT, HOLD and DISCARD.
REQ-017 imem_req SHALL be 1 only in WAIT or DISCARD, and SHALL be decoded from state alone.
REQ-018 imem_addr SHALL equal the pc register in WAIT, and the abandoned pc in DISCARD.
REQ-019 While imem_req=1, imem_addr SHALL stay stable until the cycle imem_ack=1.
REQ-020 IDLE SHALL go to WAIT unconditionally on the next edge.
REQ-021 WAIT with ack=1 and redirect_valid=1:
  - pc <= redirect_pc
  - data dropped
  - id_valid <= 0
  - stay in WAIT
REQ-022 WAIT with ack=1, no redirect, stall=0:
  - id_inst <= imem_rdata
  - id_pc <= pc
  - id_valid <= 1
  - pc <= pc+PC_STEP
  - stay in WAIT
REQ-023 WAIT with ack=1, no redirect, stall=1:
  - imem_rdata and pc captured into a one-entry hold buffer
  - pc <= pc+PC_STEP
  - id_* registers unchanged
  - go to HOLD
REQ-024 WAIT with ack=0 and redirect_valid=1:
  - redirect_pc stored as pending target
  - id_valid <= 0
  - go to DISCARD
REQ-025 WAIT with ack=0 and no redirect: id_valid <= 0 if stall=0; id_* registers held if stall=1.
REQ-026 HOLD with redirect_valid=1:
  - buffer dropped
  - pc <= redirect_pc
  - id_valid <= 0
  - go to WAIT
REQ-027 HOLD with no redirect and stall=0:
  - id_inst/id_pc <= buffer
  - id_valid <= 1
  - go to WAIT
REQ-028 HOLD with stall=1: state and all id_* registers held.
REQ-029 DISCARD SHALL keep requesting until ack; on ack it SHALL drop the data, set pc <= pending target and go to WAIT.
REQ-030 A redirect in DISCARD SHALL overwrite the pending target (latest wins).
REQ-031 id_valid SHALL be 0 throughout DISCARD.
REQ-032 redirect_valid SHALL take priority over stall in every state.
REQ-033 id_imm_field SHALL always equal id_inst[21:0].
REQ-034 PC arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFF + 1 -> 0).
REQ-035 Fetch-to-decode latency SHALL be one edge after ack when stall=0.
REQ-036 Every acked, non-discarded instruction SHALL reach id_inst exactly once, in order.

Reset
REQ-037 While rst_n=0, outputs SHALL be: state=IDLE, pc=RESET_PC, imem_req=0, id_valid=0, id_inst=0, id_imm_field=0, id_pc=0, hold buffer cleared, pending target=0.
REQ-038 Reset assertion mid-transaction SHALL abandon any outstanding request with no further effect; an ack arriving during reset is ignored.
REQ-039 The first request after rst_n rises SHALL be issued one cycle later, at imem_addr=RESET_PC.

Verification
REQ-040 Zero-wait memory, stall=0, rdata=addr+32'hA000 -> id_pc sequence 0,1,2,3 with id_valid=1 every cycle from cycle 2.
REQ-041 Ack at addr 5 while stall=1 for 3 cycles -> HOLD entered, imem_req=0, id_* unchanged; on release id_inst=word@5, id_pc=5, next request addr 6.
REQ-042 Request at addr 8 with ack delayed 4 cycles; redirect to 32'h40 in cycle 1 -> imem_addr stays 8 until ack, word@8 never appears, next request addr 32'h40, id_valid=0 meanwhile.
REQ-043 Two redirects during DISCARD (0x40 then 0x80) -> next request addr 0x80.
REQ-044 RESET_PC=32'hFFFF_FFFF, zero-wait memory -> id_pc sequence FFFF_FFFF, 0, 1.
REQ-045 rst_n deasserted while in WAIT with ack pending -> all outputs at reset values immediately (asynchronously); after release, first request at RESET_PC.
